id_ex_stage: RTL and testbench

ID/EX pipeline stage feeding the 32-bit ALU in the five-stage pipelined CPU. It registers decoded operands and control, translates the ALU opcode class and funct field into the 4-bit ALU operation code, and resolves data hazards. Hazards are resolved by forwarding EX/MEM and MEM/WB results onto the ALU inputs and by inserting a bubble on load-use dependencies. Its combinational outputs drive the ALU's `in1`, `in2` and `operation` directly.

---
 rtl/id_ex_stage.sv | 187 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operation decode, operand forwarding and load-use bubble insertion.
// Define ID_EX_FWD_EN to enable the forwarding muxes; otherwise hazards are resolved by stalling on any RAW.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_operation,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_W-1:0]  ex_dst,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              hazard_stall
);

  localparam logic [3:0]       OP_AND  = 4'b0000;
  localparam logic [3:0]       OP_OR   = 4'b0001;
  localparam logic [3:0]       OP_ADD  = 4'b0010;
  localparam logic [3:0]       OP_SUB  = 4'b0110;
  localparam logic [3:0]       OP_SLT  = 4'b0111;
  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] code;
    case (op)
      2'b00: code = OP_ADD;
      2'b01: code = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000: code = OP_ADD;
          6'b100010: code = OP_SUB;
          6'b100100: code = OP_AND;
          6'b100101: code = OP_OR;
          6'b101010: code = OP_SLT;
          default:   code = OP_ADD;
        endcase
      end
      default: code = OP_ADD;
    endcase
    return code;
  endfunction

  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [REG_W-1:0]  idx,
    input logic [DATA_W-1:0] reg_val,
    input logic              em_we,
    input logic [REG_W-1:0]  em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_we,
    input logic [REG_W-1:0]  mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] val;
    if (em_we && (em_rd != REG_ZERO) && (em_rd == idx)) begin
      val = em_res;
    end else if (mw_we && (mw_rd != REG_ZERO) && (mw_rd == idx)) begin
      val = mw_res;
    end else begin
      val = reg_val;
    end
    return val;
  endfunction

  logic [DATA_W-1:0] rs_data_r, rt_data_r, imm_r;
  logic [REG_W-1:0]  ex_rs_r, ex_rt_r, ex_dst_r;
  logic [3:0]        alu_op_r;
  logic              alu_src_r;
  logic              ex_valid_r, ex_reg_write_r, ex_mem_read_r, ex_mem_write_r;
  logic              ex_mem_to_reg_r, ex_branch_r;
  logic [DATA_W-1:0] fwd_a_s, fwd_b_s;
  logic              hazard_s, kill_s;

  // Forwarded operand selection for the ALU and the store path.
  always_comb begin
    fwd_a_s = rs_data_r;
    fwd_b_s = rt_data_r;
`ifdef ID_EX_FWD_EN
    fwd_a_s = fwd_pick(ex_rs_r, rs_data_r, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_result);
    fwd_b_s = fwd_pick(ex_rt_r, rt_data_r, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_result);
`endif
  end

  // Hazard detection: load-use only with forwarding, any pending RAW without it.
  always_comb begin
    hazard_s = 1'b0;
`ifdef ID_EX_FWD_EN
    hazard_s = ex_valid_r && ex_mem_read_r && (ex_dst_r != REG_ZERO) &&
               ((ex_dst_r == id_rs) || (ex_dst_r == id_rt)) && id_valid;
`else
    hazard_s = id_valid && (
      (ex_reg_write_r && (((id_rs != REG_ZERO) && (id_rs == ex_dst_r)) ||
                          ((id_rt != REG_ZERO) && (id_rt == ex_dst_r)))) ||
      (exmem_reg_write && (((id_rs != REG_ZERO) && (id_rs == exmem_rd)) ||
                           ((id_rt != REG_ZERO) && (id_rt == exmem_rd)))));
`endif
    kill_s = flush || (!stall && hazard_s);
  end

`ifndef ID_EX_FWD_EN
  // Source indices and the late writeback ports only matter when forwarding is built in.
  logic unused_fwd_s;
  assign unused_fwd_s = ^{ex_rs_r, ex_rt_r, exmem_result, memwb_reg_write, memwb_rd, memwb_result};
`endif

  // Pipeline register: reset/flush/load-use load a bubble, stall holds, otherwise capture decode.
  always_ff @(posedge clk) begin
    if (rst || kill_s) begin
      ex_valid_r      <= 1'b0;
      ex_reg_write_r  <= 1'b0;
      ex_mem_read_r   <= 1'b0;
      ex_mem_write_r  <= 1'b0;
      ex_mem_to_reg_r <= 1'b0;
      ex_branch_r     <= 1'b0;
      alu_src_r       <= 1'b0;
      alu_op_r        <= OP_ADD;
      rs_data_r       <= DATA_ZERO;
      rt_data_r       <= DATA_ZERO;
      imm_r           <= DATA_ZERO;
      ex_rs_r         <= REG_ZERO;
      ex_rt_r         <= REG_ZERO;
      ex_dst_r        <= REG_ZERO;
    end else if (!stall) begin
      ex_valid_r      <= id_valid;
      ex_reg_write_r  <= id_valid & id_reg_write;
      ex_mem_read_r   <= id_valid & id_mem_read;
      ex_mem_write_r  <= id_valid & id_mem_write;
      ex_mem_to_reg_r <= id_valid & id_mem_to_reg;
      ex_branch_r     <= id_valid & id_branch;
      alu_src_r       <= id_valid & id_alu_src;
      alu_op_r        <= alu_decode(id_alu_op, id_funct);
      rs_data_r       <= id_rs_data;
      rt_data_r       <= id_rt_data;
      imm_r           <= id_imm;
      ex_rs_r         <= id_rs;
      ex_rt_r         <= id_rt;
      ex_dst_r        <= id_reg_dst ? id_rd : id_rt;
    end
  end

  assign alu_in1       = fwd_a_s;
  assign alu_in2       = alu_src_r ? imm_r : fwd_b_s;
  assign store_data    = fwd_b_s;
  assign alu_operation = alu_op_r;
  assign ex_dst        = ex_dst_r;
  assign ex_valid      = ex_valid_r;
  assign ex_reg_write  = ex_reg_write_r;
  assign ex_mem_read   = ex_mem_read_r;
  assign ex_mem_write  = ex_mem_write_r;
  assign ex_mem_to_reg = ex_mem_to_reg_r;
  assign ex_branch     = ex_branch_r;
  assign hazard_stall  = hazard_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding checks compile in when ID_EX_FWD_EN is defined.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_in1, alu_in2, store_data;
  logic [3:0]  alu_operation;
  logic [4:0]  ex_dst;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, hazard_stall;

  int compared = 0;
  int mismatched = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_operation(alu_operation),
    .store_data(store_data), .ex_dst(ex_dst), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ctl = {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch}
  task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [6:0] ctl);
    id_valid = v; id_alu_op = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    {id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = ctl;
  endtask

  logic [1:0] dec_op  [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
  logic [5:0] dec_fn  [7] = '{6'b100100, 6'b100101, 6'b101010, 6'b111111, 6'b100100, 6'b100010, 6'b100010};
  logic [3:0] dec_exp [7] = '{4'b0000, 4'b0001, 4'b0111, 4'b0010, 4'b0110, 4'b0010, 4'b0010};

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    set_id(1'b0, 2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 7'b0000000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_op", {28'd0, alu_operation}, 32'h2);
    check("rst_in1", alu_in1, 32'd0);
    check("rst_in2", alu_in2, 32'd0);
    check("rst_store", store_data, 32'd0);
    check("rst_dst", {27'd0, ex_dst}, 32'd0);
    check("rst_regw", {31'd0, ex_reg_write}, 32'd0);
    check("rst_haz", {31'd0, hazard_stall}, 32'd0);

    // R-type sub
    set_id(1'b1, 2'b10, 6'b100010, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'd0, 7'b0110000);
    tick();
    check("sub_op", {28'd0, alu_operation}, 32'h6);
    check("sub_in1", alu_in1, 32'd9);
    check("sub_in2", alu_in2, 32'd4);
    check("sub_dst", {27'd0, ex_dst}, 32'd3);
    check("sub_valid", {31'd0, ex_valid}, 32'd1);
    check("sub_regw", {31'd0, ex_reg_write}, 32'd1);
    check("sub_haz", {31'd0, hazard_stall}, 32'd0);

    // Operation decode table
    for (int i = 0; i < 7; i++) begin
      set_id(1'b1, dec_op[i], dec_fn[i], 5'd0, 5'd0, 5'd0, 32'(i + 16), 32'd0, 32'd0, 7'b0000000);
      tick();
      check($sformatf("dec_op%0d", i), {28'd0, alu_operation}, {28'd0, dec_exp[i]});
      check($sformatf("dec_in1_%0d", i), alu_in1, 32'(i + 16));
    end

    // Invalid instruction: controls forced low
    set_id(1'b0, 2'b10, 6'b100000, 5'd0, 5'd0, 5'd2, 32'd1, 32'd1, 32'd0, 7'b0111110);
    tick();
    check("inv_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_regw", {31'd0, ex_reg_write}, 32'd0);
    check("inv_memw", {31'd0, ex_mem_write}, 32'd0);

    // Stall holds for three cycles, then flush during a stall gives a bubble
    set_id(1'b1, 2'b10, 6'b100101, 5'd0, 5'd0, 5'd4, 32'd5, 32'd3, 32'd0, 7'b0110000);
    tick();
    stall = 1'b1;
    set_id(1'b1, 2'b00, 6'd0, 5'd0, 5'd0, 5'd9, 32'hAA, 32'hBB, 32'h10, 7'b1001010);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall_op%0d", c), {28'd0, alu_operation}, 32'h1);
      check($sformatf("stall_in1_%0d", c), alu_in1, 32'd5);
      check($sformatf("stall_in2_%0d", c), alu_in2, 32'd3);
      check($sformatf("stall_dst%0d", c), {27'd0, ex_dst}, 32'd4);
      check($sformatf("stall_valid%0d", c), {31'd0, ex_valid}, 32'd1);
    end
    tick();
    check("stall2_in1", alu_in1, 32'd5);
    flush = 1'b1;
    tick();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_op", {28'd0, alu_operation}, 32'h2);
    check("flush_in1", alu_in1, 32'd0);
    check("flush_dst", {27'd0, ex_dst}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // Store word: immediate to ALU, rt to store path
    set_id(1'b1, 2'b00, 6'd0, 5'd0, 5'd6, 5'd0, 32'd0, 32'hABCD, 32'd8, 7'b1000100);
    tick();
    check("sw_in2", alu_in2, 32'd8);
    check("sw_store", store_data, 32'hABCD);
    check("sw_op", {28'd0, alu_operation}, 32'h2);
    check("sw_memw", {31'd0, ex_mem_write}, 32'd1);

    // Reset while a hazard stall is pending
    set_id(1'b1, 2'b00, 6'd0, 5'd0, 5'd7, 5'd0, 32'd0, 32'd0, 32'd4, 7'b1011010);
    tick();
    set_id(1'b1, 2'b10, 6'b100000, 5'd7, 5'd0, 5'd8, 32'h1, 32'h2, 32'd0, 7'b0110000);
    stall = 1'b1;
    #1;
    check("rstmid_haz_before", {31'd0, hazard_stall}, 32'd1);
    rst = 1'b1;
    tick();
    check("rstmid_valid", {31'd0, ex_valid}, 32'd0);
    check("rstmid_haz_after", {31'd0, hazard_stall}, 32'd0);
    check("rstmid_op", {28'd0, alu_operation}, 32'h2);
    rst = 1'b0; stall = 1'b0;

`ifdef ID_EX_FWD_EN
    // EX/MEM wins over MEM/WB; rd==0 from EX/MEM is ignored
    set_id(1'b1, 2'b10, 6'b100000, 5'd3, 5'd0, 5'd9, 32'h99, 32'd0, 32'd0, 7'b0110000);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
    #1;
    check("fwd_exmem", alu_in1, 32'h11);
    exmem_rd = 5'd0;
    #1;
    check("fwd_memwb", alu_in1, 32'h22);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0; memwb_rd = 5'd0;

    // Load-use: one bubble, then operand from MEM/WB
    set_id(1'b1, 2'b00, 6'd0, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0, 32'd4, 7'b1011010);
    tick();
    set_id(1'b1, 2'b10, 6'b100000, 5'd5, 5'd0, 5'd10, 32'd0, 32'd0, 32'd0, 7'b0110000);
    #1;
    check("lu_haz", {31'd0, hazard_stall}, 32'd1);
    tick();
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_haz_clr", {31'd0, hazard_stall}, 32'd0);
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h55;
    tick();
    check("lu_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_fwd", alu_in1, 32'h55);

    // Store data forwarded from MEM/WB while ALU takes the immediate
    memwb_rd = 5'd6; memwb_result = 32'hABCD;
    set_id(1'b1, 2'b00, 6'd0, 5'd0, 5'd6, 5'd0, 32'd0, 32'h1234, 32'd8, 7'b1000100);
    tick();
    check("swf_in2", alu_in2, 32'd8);
    check("swf_store", store_data, 32'hABCD);
    check("swf_op", {28'd0, alu_operation}, 32'h2);
    memwb_reg_write = 1'b0;
`else
    // No forwarding: stall while r7 is in EX, then while it is in EX/MEM
    set_id(1'b1, 2'b10, 6'b100000, 5'd0, 5'd0, 5'd7, 32'd1, 32'd1, 32'd0, 7'b0110000);
    tick();
    set_id(1'b1, 2'b10, 6'b100000, 5'd7, 5'd0, 5'd8, 32'h77, 32'd0, 32'd0, 7'b0110000);
    #1;
    check("raw_haz_ex", {31'd0, hazard_stall}, 32'd1);
    tick();
    check("raw_bubble1", {31'd0, ex_valid}, 32'd0);
    check("raw_bubble1_op", {28'd0, alu_operation}, 32'h2);
    exmem_reg_write = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h70;
    #1;
    check("raw_haz_exmem", {31'd0, hazard_stall}, 32'd1);
    tick();
    check("raw_bubble2", {31'd0, ex_valid}, 32'd0);
    exmem_reg_write = 1'b0;
    #1;
    check("raw_haz_clear", {31'd0, hazard_stall}, 32'd0);
    tick();
    check("raw_load_valid", {31'd0, ex_valid}, 32'd1);
    check("raw_load_in1", alu_in1, 32'h77);
    set_id(1'b1, 2'b10, 6'b100000, 5'd0, 5'd8, 5'd9, 32'd0, 32'd0, 32'd0, 7'b0110000);
    #1;
    check("raw_haz_rt", {31'd0, hazard_stall}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
